// File: rtl/pvr_vram_arb.sv
// pvr_vram_arb: round-robin arbiter sharing one VRAM port among NREQ requesters.
// Define PVR_ARB_TIMEOUT_EN to add the read-data watchdog (DEADDEAD response + sticky arb_err).
module pvr_vram_arb #(
    parameter int NREQ    = 4,
    parameter int AW      = 24,
    parameter int TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_rd,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_data,
    output logic               vram_rd,
    output logic               vram_wr,
    output logic [AW-1:0]      vram_addr,
    output logic [31:0]        vram_dout,
    input  logic               vram_wait,
    input  logic               vram_valid,
    input  logic [31:0]        vram_din,
    output logic               arb_busy,
    output logic [2:0]         arb_grant,
    output logic               arb_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t        state;
    logic [2:0]    last;
    logic [2:0]    pick;
    logic          found;
    logic          pick_rd;
    logic [AW-1:0] pick_addr;
    logic [31:0]   pick_wdata;
    int            best;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
        $error("pvr_vram_arb: unsupported parameter set");
    end

    // Smallest rotation distance from last+1 wins; read beats write within a requester.
    always_comb begin
        found      = 1'b0;
        pick       = '0;
        pick_rd    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        best       = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if ((req_rd[i] || req_wr[i]) && (((i + 2*NREQ - 1 - int'(last)) % NREQ) < best)) begin
                best       = (i + 2*NREQ - 1 - int'(last)) % NREQ;
                found      = 1'b1;
                pick       = 3'(i);
                pick_rd    = req_rd[i];
                pick_addr  = req_addr[i*AW +: AW];
                pick_wdata = req_wdata[i*32 +: 32];
            end
        end
    end

    assign arb_busy = (state != IDLE);

`ifdef PVR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`else
    assign arb_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 3'(NREQ - 1);
            arb_grant <= '0;
            vram_rd   <= 1'b0;
            vram_wr   <= 1'b0;
            vram_addr <= '0;
            vram_dout <= '0;
            req_ack   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
`ifdef PVR_ARB_TIMEOUT_EN
            cnt       <= '0;
            arb_err   <= 1'b0;
`endif
        end else begin
            req_ack   <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= ISSUE;
                        arb_grant <= pick;
                        vram_addr <= pick_addr;
                        vram_dout <= pick_wdata;
                        vram_rd   <= pick_rd;
                        vram_wr   <= !pick_rd;
                    end
                end
                ISSUE: begin
                    if (!vram_wait) begin
                        vram_rd <= 1'b0;
                        vram_wr <= 1'b0;
                        req_ack <= NREQ'(1) << arb_grant;
                        last    <= arb_grant;
                        state   <= vram_rd ? DATA : IDLE;
`ifdef PVR_ARB_TIMEOUT_EN
                        cnt     <= '0;
`endif
                    end
                end
                DATA: begin
                    if (vram_valid) begin
                        rsp_data  <= vram_din;
                        rsp_valid <= NREQ'(1) << arb_grant;
                        state     <= IDLE;
`ifdef PVR_ARB_TIMEOUT_EN
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_data  <= 32'hDEADDEAD;
                        rsp_valid <= NREQ'(1) << arb_grant;
                        arb_err   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pvr_vram_arb.sv
// tb_pvr_vram_arb: directed + random bench for pvr_vram_arb against a transaction-level model.
module tb_pvr_vram_arb;
    localparam int NREQ = 4;
    localparam int AW   = 24;
    localparam int TO   = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NREQ-1:0]    req_rd, req_wr, req_ack, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [31:0]        rsp_data, vram_dout, vram_din;
    logic               vram_rd, vram_wr, vram_wait, vram_valid, arb_busy, arb_err;
    logic [AW-1:0]      vram_addr;
    logic [2:0]         arb_grant;

    pvr_vram_arb #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .vram_rd(vram_rd), .vram_wr(vram_wr), .vram_addr(vram_addr), .vram_dout(vram_dout),
        .vram_wait(vram_wait), .vram_valid(vram_valid), .vram_din(vram_din),
        .arb_busy(arb_busy), .arb_grant(arb_grant), .arb_err(arb_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Transaction-level model: pending requests, round-robin pointer, one VRAM transfer in flight.
    typedef enum {P_IDLE, P_ISSUE, P_DATA} phase_t;
    phase_t          phase;
    bit              prd[NREQ], pwr[NREQ];
    logic [AW-1:0]   paddr[NREQ];
    logic [31:0]     pdata[NREQ];
    logic [31:0]     mem[bit [AW-1:0]];
    int              last, g, wait_left, dly, tcnt, exp_grant;
    bit              t_rd, exp_vrd, exp_vwr, exp_err, new_issue;
    logic [AW-1:0]   t_addr;
    logic [31:0]     t_data, exp_rd;
    logic [NREQ-1:0] exp_ack, exp_rv;
    bit              rand_en, sticky, hang;
    int              wait_cfg, dly_cfg;
    int              grant_log[$];
    int              rr_exp[5] = '{0, 1, 2, 3, 0};

    function automatic int rr_pick();
        for (int k = 1; k <= NREQ; k++)
            if (prd[(last + k) % NREQ] || pwr[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic check_outputs();
        check("req_ack", 32'(req_ack), 32'(exp_ack));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv != 0) check("rsp_data", rsp_data, exp_rd);
        check("vram_rd", 32'(vram_rd), 32'(exp_vrd));
        check("vram_wr", 32'(vram_wr), 32'(exp_vwr));
        check("arb_busy", 32'(arb_busy), 32'(phase != P_IDLE));
        check("arb_err", 32'(arb_err), 32'(exp_err));
        if (exp_vrd || exp_vwr) begin
            check("arb_grant", 32'(arb_grant), 32'(exp_grant));
            check("vram_addr", 32'(vram_addr), 32'(t_addr));
            if (exp_vwr) check("vram_dout", vram_dout, t_data);
        end
        if (new_issue) grant_log.push_back(int'(arb_grant));
        new_issue = 1'b0;
    endtask

    task automatic drop_acked();
        if (sticky) return;
        for (int i = 0; i < NREQ; i++)
            if (exp_ack[i]) begin
                if (t_rd) prd[i] = 1'b0;
                else pwr[i] = 1'b0;
            end
    endtask

    task automatic gen_reqs();
        for (int i = 0; i < NREQ; i++)
            if (!prd[i] && !pwr[i] && $urandom_range(0, 3) == 0) begin
                int k = int'($urandom_range(1, 3));
                prd[i]   = k[0];
                pwr[i]   = k[1];
                paddr[i] = 24'h000100 + AW'($urandom_range(0, 7) * 4);
                pdata[i] = $urandom;
            end
    endtask

    // Drives requests and VRAM responses for the next edge and records what must follow it.
    task automatic decide();
        int w;
        for (int i = 0; i < NREQ; i++) begin
            req_rd[i]               = prd[i];
            req_wr[i]               = pwr[i];
            req_addr[i*AW +: AW]    = paddr[i];
            req_wdata[i*32 +: 32]   = pdata[i];
        end
        exp_ack    = '0;
        exp_rv     = '0;
        vram_valid = 1'b0;
        vram_din   = $urandom;
        vram_wait  = 1'($urandom_range(0, 1));
        case (phase)
            P_IDLE: begin
                vram_valid = ($urandom_range(0, 3) == 0);
                w = rr_pick();
                if (w >= 0) begin
                    g         = w;
                    t_rd      = prd[w];
                    t_addr    = paddr[w];
                    t_data    = pdata[w];
                    exp_vrd   = t_rd;
                    exp_vwr   = !t_rd;
                    exp_grant = w;
                    new_issue = 1'b1;
                    phase     = P_ISSUE;
                    wait_left = (wait_cfg >= 0) ? wait_cfg : int'($urandom_range(0, 3));
                end
            end
            P_ISSUE: begin
                vram_valid = ($urandom_range(0, 3) == 0);
                vram_wait  = (wait_left > 0);
                if (wait_left > 0) wait_left--;
                else begin
                    exp_vrd = 1'b0;
                    exp_vwr = 1'b0;
                    exp_ack = NREQ'(1) << g;
                    last    = g;
                    if (t_rd) begin
                        phase = P_DATA;
                        dly   = hang ? -1 : ((dly_cfg >= 0) ? dly_cfg : int'($urandom_range(0, 4)));
                        tcnt  = 0;
                    end else begin
                        mem[t_addr] = t_data;
                        phase = P_IDLE;
                    end
                end
            end
            default: begin
                if (dly == 0) begin
                    vram_valid = 1'b1;
                    if (mem.exists(t_addr)) vram_din = mem[t_addr];
                    exp_rv = NREQ'(1) << g;
                    exp_rd = vram_din;
                    phase  = P_IDLE;
                end else begin
                    if (dly > 0) dly--;
`ifdef PVR_ARB_TIMEOUT_EN
                    if (tcnt == TO - 1) begin
                        exp_rv  = NREQ'(1) << g;
                        exp_rd  = 32'hDEADDEAD;
                        exp_err = 1'b1;
                        phase   = P_IDLE;
                    end
                    tcnt++;
`endif
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        check_outputs();
        drop_acked();
        if (rand_en) gen_reqs();
        decide();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        vram_valid = 1'b1;
        vram_wait  = 1'b0;
        vram_din   = 32'h5555AAAA;
        @(posedge clock);
        @(negedge clock);
        check("rst_vram_rd", 32'(vram_rd), 0);
        check("rst_vram_wr", 32'(vram_wr), 0);
        check("rst_req_ack", 32'(req_ack), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", 32'(arb_busy), 0);
        check("rst_grant", 32'(arb_grant), 0);
        check("rst_addr", 32'(vram_addr), 0);
        check("rst_err", 32'(arb_err), 0);
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            prd[i]   = 1'b0;
            pwr[i]   = 1'b0;
            paddr[i] = '0;
            pdata[i] = '0;
        end
        phase   = P_IDLE;
        last    = NREQ - 1;
        exp_ack = '0;
        exp_rv  = '0;
        exp_vrd = 1'b0;
        exp_vwr = 1'b0;
        exp_err = 1'b0;
        sticky  = 1'b0;
        hang    = 1'b0;
        new_issue = 1'b0;
        decide();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rand_en  = 1'b0;
        wait_cfg = -1;
        dly_cfg  = -1;
        req_rd   = '0;
        req_wr   = '0;
        req_addr = '0;
        req_wdata = '0;
        @(negedge clock);
        do_reset();

        // Single read with immediate accept and delayed data.
        mem[24'h000100] = 32'h12345678;
        prd[0] = 1'b1; paddr[0] = 24'h000100; wait_cfg = 0; dly_cfg = 3;
        run(12);

        // Write stalled five cycles, then read it back from another requester.
        pwr[2] = 1'b1; paddr[2] = 24'h0ABCDE; pdata[2] = 32'hCAFEF00D; wait_cfg = 5;
        run(12);
        prd[3] = 1'b1; paddr[3] = 24'h0ABCDE; wait_cfg = 0; dly_cfg = 0;
        run(8);

        // Read and write from one requester: read first, write next.
        prd[1] = 1'b1; pwr[1] = 1'b1; paddr[1] = 24'h000200; pdata[1] = 32'h0BADBEEF;
        wait_cfg = -1; dly_cfg = -1;
        run(30);

        // All requesters held high from reset rotate 0,1,2,3,0.
        do_reset();
        sticky = 1'b1; wait_cfg = 0; dly_cfg = 0;
        for (int i = 0; i < NREQ; i++) begin
            prd[i] = 1'b1; paddr[i] = AW'(24'h000300 + i * 4);
        end
        grant_log.delete();
        for (int c = 0; c < 100 && grant_log.size() < 5; c++) tick();
        check("rr_count", 32'(grant_log.size()), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) check("rr_order", 32'(grant_log[k]), 32'(rr_exp[k]));

        // Reset during ISSUE, then during DATA; first grant afterwards is requester 0.
        do_reset();
        prd[2] = 1'b1; paddr[2] = 24'h000400; wait_cfg = 3;
        run(2);
        do_reset();
        hang = 1'b1; wait_cfg = 0;
        prd[2] = 1'b1; paddr[2] = 24'h000400;
        run(3);
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            prd[i] = 1'b1; paddr[i] = AW'(24'h000500 + i * 4);
        end
        grant_log.delete();
        run(2);
        check("post_rst_log", 32'(grant_log.size()), 1);
        if (grant_log.size() > 0) check("post_rst_grant", 32'(grant_log[0]), 0);
        run(40);

        // Random traffic with random stalls, read latencies and spurious vram_valid.
        do_reset();
        rand_en = 1'b1; wait_cfg = -1; dly_cfg = -1;
        run(3000);
        rand_en = 1'b0;
        run(80);

`ifdef PVR_ARB_TIMEOUT_EN
        // Read whose data never returns: watchdog answers DEADDEAD and latches arb_err.
        do_reset();
        hang = 1'b1; wait_cfg = 0;
        prd[1] = 1'b1; paddr[1] = 24'h000600;
        run(30);
        check("err_sticky", 32'(arb_err), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
